// File: rtl/rs_scheduler.sv
// rs_scheduler: partitioned reservation station with slot-bitmask wakeup and age-matrix oldest-ready select.
// disp_pkt[FU_W-1:0] carries fu_sel. Define RS_PERF_CNT_EN to add the performance counter outputs.
module rs_scheduler #(
    parameter int NUM_FUS    = 4,
    parameter int RS_ENTRIES = 4,
    parameter int PKT_W      = 16,
    localparam int TOT_SLOTS = NUM_FUS * RS_ENTRIES,
    localparam int SLOT_W    = $clog2(TOT_SLOTS),
    localparam int FU_W      = (NUM_FUS > 1) ? $clog2(NUM_FUS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PKT_W-1:0]            disp_pkt,
    input  logic                        disp_valid,
    input  logic [TOT_SLOTS-1:0]        dependency_mask,
    output logic [SLOT_W-1:0]           rs_entry_idx,
    output logic                        rs_full,
    input  logic                        flush,
    input  logic [NUM_FUS-1:0]          fu_ready,
    output logic [NUM_FUS-1:0]          issue_valid,
    output logic [NUM_FUS*PKT_W-1:0]    issue_pkt,
    output logic [NUM_FUS*SLOT_W-1:0]   issue_slot
`ifdef RS_PERF_CNT_EN
    ,
    output logic [31:0]                 perf_full_cycles,
    output logic [NUM_FUS*32-1:0]       perf_issue_cnt,
    output logic [NUM_FUS*32-1:0]       perf_stall_cycles
`endif
);

    logic [TOT_SLOTS-1:0]  valid_q, valid_d;
    logic [PKT_W-1:0]      pkt_q  [TOT_SLOTS];
    logic [PKT_W-1:0]      pkt_d  [TOT_SLOTS];
    logic [TOT_SLOTS-1:0]  mask_q [TOT_SLOTS];
    logic [TOT_SLOTS-1:0]  mask_d [TOT_SLOTS];
    // age_q[f][i][j] set means local slot i of partition f was dispatched before local slot j
    logic [RS_ENTRIES-1:0] age_q  [NUM_FUS][RS_ENTRIES];
    logic [RS_ENTRIES-1:0] age_d  [NUM_FUS][RS_ENTRIES];

    logic [TOT_SLOTS-1:0]  ready_vec;
    logic [TOT_SLOTS-1:0]  older_ready_vec;
    logic [TOT_SLOTS-1:0]  issuing_vec;
    logic [FU_W-1:0]       alloc_fu;
    logic                  alloc;
    logic [SLOT_W-1:0]     alloc_slot;

    assign alloc_fu = disp_pkt[FU_W-1:0];

    always_comb begin
        rs_full = 1'b0;
        for (int f = 0; f < NUM_FUS; f++)
            if (&valid_q[f*RS_ENTRIES +: RS_ENTRIES]) rs_full = 1'b1;
    end

    always_comb begin
        alloc      = disp_valid && !rs_full && !flush;
        alloc_slot = '0;
        for (int f = 0; f < NUM_FUS; f++)
            if (int'(alloc_fu) == f)
                for (int i = RS_ENTRIES - 1; i >= 0; i--)
                    if (!valid_q[f*RS_ENTRIES+i]) alloc_slot = SLOT_W'(f*RS_ENTRIES + i);
        rs_entry_idx = alloc ? alloc_slot : '0;
    end

    always_comb begin
        for (int s = 0; s < TOT_SLOTS; s++)
            ready_vec[s] = valid_q[s] && (mask_q[s] == '0);
    end

    // A ready slot is blocked if any other ready slot in its partition is older.
    always_comb begin
        older_ready_vec = '0;
        for (int f = 0; f < NUM_FUS; f++)
            for (int i = 0; i < RS_ENTRIES; i++)
                for (int j = 0; j < RS_ENTRIES; j++)
                    if (ready_vec[f*RS_ENTRIES+j] && age_q[f][j][i])
                        older_ready_vec[f*RS_ENTRIES+i] = 1'b1;
    end

    always_comb begin
        issue_valid = '0;
        issue_pkt   = '0;
        issue_slot  = '0;
        issuing_vec = '0;
        for (int f = 0; f < NUM_FUS; f++)
            for (int i = 0; i < RS_ENTRIES; i++)
                if (ready_vec[f*RS_ENTRIES+i] && !older_ready_vec[f*RS_ENTRIES+i]) begin
                    issue_valid[f]                   = 1'b1;
                    issue_pkt[f*PKT_W +: PKT_W]      = pkt_q[f*RS_ENTRIES+i];
                    issue_slot[f*SLOT_W +: SLOT_W]   = SLOT_W'(f*RS_ENTRIES + i);
                    issuing_vec[f*RS_ENTRIES+i]      = fu_ready[f];
                end
    end

    always_comb begin
        valid_d = valid_q & ~issuing_vec;
        for (int s = 0; s < TOT_SLOTS; s++) begin
            pkt_d[s]  = pkt_q[s];
            mask_d[s] = mask_q[s] & ~issuing_vec;
            if (alloc && (SLOT_W'(s) == alloc_slot)) begin
                valid_d[s] = 1'b1;
                pkt_d[s]   = disp_pkt;
                mask_d[s]  = dependency_mask & valid_q & ~issuing_vec & ~(TOT_SLOTS'(1) << s);
            end
        end
        for (int f = 0; f < NUM_FUS; f++)
            for (int i = 0; i < RS_ENTRIES; i++)
                for (int j = 0; j < RS_ENTRIES; j++) begin
                    age_d[f][i][j] = age_q[f][i][j] &&
                                     !issuing_vec[f*RS_ENTRIES+i] && !issuing_vec[f*RS_ENTRIES+j];
                    // The new entry is younger than every survivor of this edge.
                    if (alloc && (SLOT_W'(f*RS_ENTRIES + i) == alloc_slot))
                        age_d[f][i][j] = 1'b0;
                    if (alloc && (SLOT_W'(f*RS_ENTRIES + j) == alloc_slot))
                        age_d[f][i][j] = valid_q[f*RS_ENTRIES+i] && !issuing_vec[f*RS_ENTRIES+i];
                end
        if (flush) begin
            valid_d = '0;
            for (int s = 0; s < TOT_SLOTS; s++) begin
                pkt_d[s]  = '0;
                mask_d[s] = '0;
            end
            for (int f = 0; f < NUM_FUS; f++)
                for (int i = 0; i < RS_ENTRIES; i++)
                    age_d[f][i] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int s = 0; s < TOT_SLOTS; s++) begin
                pkt_q[s]  <= '0;
                mask_q[s] <= '0;
            end
            for (int f = 0; f < NUM_FUS; f++)
                for (int i = 0; i < RS_ENTRIES; i++)
                    age_q[f][i] <= '0;
        end else begin
            valid_q <= valid_d;
            for (int s = 0; s < TOT_SLOTS; s++) begin
                pkt_q[s]  <= pkt_d[s];
                mask_q[s] <= mask_d[s];
            end
            for (int f = 0; f < NUM_FUS; f++)
                for (int i = 0; i < RS_ENTRIES; i++)
                    age_q[f][i] <= age_d[f][i];
        end
    end

    a_no_disp_when_full: assert property (@(posedge clk) disable iff (rst) !(disp_valid && rs_full));

`ifdef RS_PERF_CNT_EN
    logic [31:0] perf_full_q, perf_full_d;
    logic [31:0] perf_issue_q [NUM_FUS];
    logic [31:0] perf_issue_d [NUM_FUS];
    logic [31:0] perf_stall_q [NUM_FUS];
    logic [31:0] perf_stall_d [NUM_FUS];

    // Counters survive flush; only rst clears them.
    always_comb begin
        perf_full_d       = perf_full_q + 32'(disp_valid && rs_full);
        perf_full_cycles  = perf_full_q;
        perf_issue_cnt    = '0;
        perf_stall_cycles = '0;
        for (int f = 0; f < NUM_FUS; f++) begin
            perf_issue_d[f] = perf_issue_q[f] + 32'(issue_valid[f] && fu_ready[f]);
            perf_stall_d[f] = perf_stall_q[f] +
                              32'((|valid_q[f*RS_ENTRIES +: RS_ENTRIES]) &&
                                  !(|ready_vec[f*RS_ENTRIES +: RS_ENTRIES]));
            perf_issue_cnt[f*32 +: 32]    = perf_issue_q[f];
            perf_stall_cycles[f*32 +: 32] = perf_stall_q[f];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_full_q <= '0;
            for (int f = 0; f < NUM_FUS; f++) begin
                perf_issue_q[f] <= '0;
                perf_stall_q[f] <= '0;
            end
        end else begin
            perf_full_q <= perf_full_d;
            for (int f = 0; f < NUM_FUS; f++) begin
                perf_issue_q[f] <= perf_issue_d[f];
                perf_stall_q[f] <= perf_stall_d[f];
            end
        end
    end
`else
    // Counters compiled out: no perf state or ports exist in this build.
`endif

endmodule

// File: tb/tb_rs_scheduler.sv
// Directed testbench for rs_scheduler: allocation, wakeup, full, age order, same-cycle mask pruning, flush.
// Inputs change at the falling edge; outputs are checked 1 time unit later.
module tb_rs_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] disp_pkt;
    logic        disp_valid;
    logic [15:0] dependency_mask;
    logic [3:0]  rs_entry_idx;
    logic        rs_full;
    logic        flush;
    logic [3:0]  fu_ready;
    logic [3:0]  issue_valid;
    logic [63:0] issue_pkt;
    logic [15:0] issue_slot;

    int vec_count  = 0;
    int miss_count = 0;

    always #5 clk = ~clk;

    rs_scheduler #(.NUM_FUS(4), .RS_ENTRIES(4), .PKT_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .disp_pkt        (disp_pkt),
        .disp_valid      (disp_valid),
        .dependency_mask (dependency_mask),
        .rs_entry_idx    (rs_entry_idx),
        .rs_full         (rs_full),
        .flush           (flush),
        .fu_ready        (fu_ready),
        .issue_valid     (issue_valid),
        .issue_pkt       (issue_pkt),
        .issue_slot      (issue_slot)
    );

    function automatic logic [15:0] mk_pkt(input int tag, input int fu);
        return {14'(tag), 2'(fu)};
    endfunction

    task automatic applyStimulus(input logic v, input logic [15:0] pkt, input logic [15:0] mask,
                                 input logic [3:0] rdy, input logic fl);
        @(negedge clk);
        disp_valid      = v;
        disp_pkt        = pkt;
        dependency_mask = mask;
        fu_ready        = rdy;
        flush           = fl;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; disp_valid = 1'b0; disp_pkt = '0; dependency_mask = '0; fu_ready = '0; flush = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        applyStimulus(1'b1, mk_pkt(1, 0), 16'h0, 4'b0000, 1'b0);
        applyStimulus(1'b1, mk_pkt(2, 1), 16'h0, 4'b0000, 1'b0);
        vec_count++;
        if (issue_valid !== 4'b0001) begin miss_count++; $display("[TB] FAIL pre_reset_valid: got %b expected 0001", issue_valid); end
        @(negedge clk);
        rst = 1'b1; disp_valid = 1'b0; disp_pkt = '0;
        @(negedge clk);
        #1;
        vec_count++;
        if (issue_valid !== 4'b0000) begin miss_count++; $display("[TB] FAIL reset_issue_valid: got %b expected 0000", issue_valid); end
        vec_count++;
        if (rs_full !== 1'b0) begin miss_count++; $display("[TB] FAIL reset_rs_full: got %b expected 0", rs_full); end
        vec_count++;
        if (issue_slot !== 16'h0 || issue_pkt !== 64'h0) begin miss_count++; $display("[TB] FAIL reset_issue_zero: got slot %h pkt %h expected 0", issue_slot, issue_pkt); end
        rst = 1'b0;
        applyStimulus(1'b0, 16'h0, 16'h0, 4'b0000, 1'b0);
        vec_count++;
        if (issue_valid !== 4'b0000) begin miss_count++; $display("[TB] FAIL post_reset_valid: got %b expected 0000", issue_valid); end
    endtask

    task automatic test_basic_issue();
        logic [15:0] p1;
        p1 = mk_pkt(10, 1);
        do_reset();
        applyStimulus(1'b1, p1, 16'h0, 4'b0000, 1'b0);
        vec_count++;
        if (rs_entry_idx !== 4'd4) begin miss_count++; $display("[TB] FAIL basic_alloc_idx: got %0d expected 4", rs_entry_idx); end
        applyStimulus(1'b0, 16'h0, 16'h0, 4'b0000, 1'b0);
        vec_count++;
        if (issue_valid !== 4'b0010) begin miss_count++; $display("[TB] FAIL basic_issue_valid: got %b expected 0010", issue_valid); end
        vec_count++;
        if (issue_slot[7:4] !== 4'd4 || issue_pkt[31:16] !== p1) begin miss_count++; $display("[TB] FAIL basic_issue_sel: got slot %0d pkt %h expected 4 %h", issue_slot[7:4], issue_pkt[31:16], p1); end
        applyStimulus(1'b0, 16'h0, 16'h0, 4'b0010, 1'b0);
        applyStimulus(1'b0, 16'h0, 16'h0, 4'b0000, 1'b0);
        vec_count++;
        if (issue_valid !== 4'b0000) begin miss_count++; $display("[TB] FAIL basic_freed: got %b expected 0000", issue_valid); end
        applyStimulus(1'b1, mk_pkt(11, 1), 16'h0, 4'b0000, 1'b0);
        vec_count++;
        if (rs_entry_idx !== 4'd4) begin miss_count++; $display("[TB] FAIL basic_realloc_idx: got %0d expected 4", rs_entry_idx); end
    endtask

    task automatic test_wakeup();
        logic [15:0] pa, pb;
        pa = mk_pkt(20, 0);
        pb = mk_pkt(21, 2);
        do_reset();
        applyStimulus(1'b1, pa, 16'h0, 4'b0000, 1'b0);
        vec_count++;
        if (rs_entry_idx !== 4'd0) begin miss_count++; $display("[TB] FAIL wake_idx_a: got %0d expected 0", rs_entry_idx); end
        applyStimulus(1'b1, pb, 16'h0001, 4'b0000, 1'b0);
        vec_count++;
        if (rs_entry_idx !== 4'd8) begin miss_count++; $display("[TB] FAIL wake_idx_b: got %0d expected 8", rs_entry_idx); end
        applyStimulus(1'b0, 16'h0, 16'h0, 4'b0000, 1'b0);
        vec_count++;
        if (issue_valid !== 4'b0001) begin miss_count++; $display("[TB] FAIL wake_b_blocked: got %b expected 0001", issue_valid); end
        applyStimulus(1'b0, 16'h0, 16'h0, 4'b0001, 1'b0);
        applyStimulus(1'b0, 16'h0, 16'h0, 4'b0000, 1'b0);
        vec_count++;
        if (issue_valid !== 4'b0100) begin miss_count++; $display("[TB] FAIL wake_b_ready: got %b expected 0100", issue_valid); end
        vec_count++;
        if (issue_slot[11:8] !== 4'd8 || issue_pkt[47:32] !== pb) begin miss_count++; $display("[TB] FAIL wake_b_sel: got slot %0d pkt %h expected 8 %h", issue_slot[11:8], issue_pkt[47:32], pb); end
    endtask

    task automatic test_full();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, mk_pkt(30 + k, 3), 16'h0, 4'b0000, 1'b0);
            vec_count++;
            if (rs_entry_idx !== 4'(12 + k)) begin miss_count++; $display("[TB] FAIL full_fill_idx%0d: got %0d expected %0d", k, rs_entry_idx, 12 + k); end
        end
        applyStimulus(1'b0, 16'h0, 16'h0, 4'b0000, 1'b0);
        vec_count++;
        if (rs_full !== 1'b1 || issue_slot[15:12] !== 4'd12) begin miss_count++; $display("[TB] FAIL full_set: got full %b slot %0d expected 1 12", rs_full, issue_slot[15:12]); end
        applyStimulus(1'b0, 16'h0, 16'h0, 4'b1000, 1'b0);
        vec_count++;
        if (rs_full !== 1'b1) begin miss_count++; $display("[TB] FAIL full_no_bypass: got %b expected 1", rs_full); end
        applyStimulus(1'b0, 16'h0, 16'h0, 4'b0000, 1'b0);
        vec_count++;
        if (rs_full !== 1'b0 || issue_slot[15:12] !== 4'd13) begin miss_count++; $display("[TB] FAIL full_clear: got full %b slot %0d expected 0 13", rs_full, issue_slot[15:12]); end
        applyStimulus(1'b1, mk_pkt(40, 3), 16'h0, 4'b0000, 1'b0);
        vec_count++;
        if (rs_entry_idx !== 4'd12) begin miss_count++; $display("[TB] FAIL full_reuse_idx: got %0d expected 12", rs_entry_idx); end
    endtask

    task automatic test_age_order();
        logic [15:0] px, pc, pd;
        px = mk_pkt(50, 0);
        pc = mk_pkt(51, 0);
        pd = mk_pkt(52, 0);
        do_reset();
        applyStimulus(1'b1, px, 16'h0, 4'b0000, 1'b0);
        applyStimulus(1'b1, pc, 16'h0, 4'b0001, 1'b0);
        vec_count++;
        if (rs_entry_idx !== 4'd1 || issue_slot[3:0] !== 4'd0) begin miss_count++; $display("[TB] FAIL age_c_alloc: got idx %0d slot %0d expected 1 0", rs_entry_idx, issue_slot[3:0]); end
        applyStimulus(1'b1, pd, 16'h0, 4'b0000, 1'b0);
        vec_count++;
        if (rs_entry_idx !== 4'd0) begin miss_count++; $display("[TB] FAIL age_d_alloc: got %0d expected 0", rs_entry_idx); end
        applyStimulus(1'b0, 16'h0, 16'h0, 4'b0000, 1'b0);
        vec_count++;
        if (issue_slot[3:0] !== 4'd1 || issue_pkt[15:0] !== pc) begin miss_count++; $display("[TB] FAIL age_c_first: got slot %0d pkt %h expected 1 %h", issue_slot[3:0], issue_pkt[15:0], pc); end
        applyStimulus(1'b0, 16'h0, 16'h0, 4'b0001, 1'b0);
        applyStimulus(1'b0, 16'h0, 16'h0, 4'b0001, 1'b0);
        vec_count++;
        if (issue_slot[3:0] !== 4'd0 || issue_pkt[15:0] !== pd) begin miss_count++; $display("[TB] FAIL age_d_second: got slot %0d pkt %h expected 0 %h", issue_slot[3:0], issue_pkt[15:0], pd); end
        applyStimulus(1'b0, 16'h0, 16'h0, 4'b0000, 1'b0);
        vec_count++;
        if (issue_valid !== 4'b0000) begin miss_count++; $display("[TB] FAIL age_drained: got %b expected 0000", issue_valid); end
    endtask

    task automatic test_same_cycle_mask();
        do_reset();
        applyStimulus(1'b1, mk_pkt(60, 1), 16'h0, 4'b0000, 1'b0);
        applyStimulus(1'b1, mk_pkt(61, 2), 16'h0310, 4'b0010, 1'b0);
        vec_count++;
        if (rs_entry_idx !== 4'd8) begin miss_count++; $display("[TB] FAIL mask_q_idx: got %0d expected 8", rs_entry_idx); end
        applyStimulus(1'b1, mk_pkt(62, 3), 16'h0020, 4'b0000, 1'b0);
        vec_count++;
        if (issue_valid !== 4'b0100 || issue_slot[11:8] !== 4'd8) begin miss_count++; $display("[TB] FAIL mask_issuing_dropped: got %b slot %0d expected 0100 8", issue_valid, issue_slot[11:8]); end
        applyStimulus(1'b0, 16'h0, 16'h0, 4'b0000, 1'b0);
        vec_count++;
        if (issue_valid !== 4'b1100 || issue_slot[15:12] !== 4'd12) begin miss_count++; $display("[TB] FAIL mask_empty_dropped: got %b slot %0d expected 1100 12", issue_valid, issue_slot[15:12]); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int k = 0; k < 6; k++)
            applyStimulus(1'b1, mk_pkt(70 + k, k / 2), 16'h0, 4'b0000, 1'b0);
        applyStimulus(1'b1, mk_pkt(80, 3), 16'h0, 4'b0000, 1'b1);
        vec_count++;
        if (issue_valid !== 4'b0111 || rs_entry_idx !== 4'd0) begin miss_count++; $display("[TB] FAIL flush_pre: got %b idx %0d expected 0111 0", issue_valid, rs_entry_idx); end
        applyStimulus(1'b0, 16'h0, 16'h0, 4'b0000, 1'b0);
        vec_count++;
        if (issue_valid !== 4'b0000 || rs_full !== 1'b0) begin miss_count++; $display("[TB] FAIL flush_cleared: got %b full %b expected 0000 0", issue_valid, rs_full); end
        applyStimulus(1'b1, mk_pkt(81, 1), 16'h0, 4'b0000, 1'b0);
        vec_count++;
        if (rs_entry_idx !== 4'd4) begin miss_count++; $display("[TB] FAIL flush_realloc: got %0d expected 4", rs_entry_idx); end
    endtask

    initial begin
        rst = 1'b1; disp_valid = 1'b0; disp_pkt = '0; dependency_mask = '0; fu_ready = '0; flush = 1'b0;
        $display("[TB] rs_scheduler directed test start");
        test_reset();
        test_basic_issue();
        test_wakeup();
        test_full();
        test_age_order();
        test_same_cycle_mask();
        test_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end
endmodule
